calc_port_scheduler: RTL and testbench
======================================

Name: calc_port_scheduler

Overview:
- Shares one Calc3 request/response port between NREQ independent requesters.
- Arbitrates round-robin, allocates a free 2-bit tag per command and drives the two-cycle Calc3 request sequence.
- Routes each tagged response back to the requester that issued it.
- Sits between the testbench agents or a host block and one DUT port, e.g. port 2: `req2_*` / `out2_*`.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NTAG, 4, number of tags in the pool; tag width is fixed at 2 bits, so NTAG is at most 4.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid & ready are both high
- req_cmd  in  4*NREQ  command, requester i at bits [4i+3:4i]
- req_op1  in  32*NREQ  operand 1
- req_op2  in  32*NREQ  operand 2
- dut_cmd  out  4  to DUT `reqN_cmd`
- dut_data  out  32  to DUT `reqN_data`
- dut_tag  out  2  to DUT `reqN_tag`
- dut_resp  in  2  from DUT `outN_resp` (0 = none, 1 = ok, 2 = error, 3 = unused)
- dut_out_data  in  32  from DUT `outN_data`
- dut_out_tag  in  2  from DUT `outN_tag`
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse to the owning requester
- rsp_code  out  2  copy of dut_resp
- rsp_data  out  32  copy of dut_out_data
- busy_tags  out  NTAG  tag-in-use bitmap
- spurious  out  1  1-cycle pulse: response on a tag not in use, or resp==3

Behaviour:
- Reset, asynchronous on reset_n low: all outputs 0, FSM in IDLE, busy_tags=0, RR pointer=0.
- Reset mid-sequence: the outstanding command and all tag ownership are discarded. A late DUT response afterwards raises spurious.
- FSM states: IDLE, ISSUE1, ISSUE2. All dut_* outputs are registered.
- Grant window: while in IDLE or ISSUE2, req_ready is asserted combinationally to exactly one requester. That requester must satisfy all of:
  - req_valid high;
  - req_cmd nonzero (cmd 0 is never granted);
  - at least one free tag exists.
- Arbitration: round-robin, searching from (last granted + 1) mod NREQ. The pointer updates only on a grant.
- Tag allocation: lowest-index free tag taken from the registered busy_tags. The grant latches cmd, op1, op2, requester index and tag, and sets busy_tags[tag].
- Transitions:
  - Grant in IDLE or ISSUE2 -> ISSUE1.
  - ISSUE1 -> ISSUE2 unconditionally.
  - ISSUE2 with no grant -> IDLE.
- Cycle after entering ISSUE1: dut_cmd=cmd, dut_data=op1, dut_tag=tag.
- ISSUE2 cycle: dut_cmd=0, dut_data=op2, dut_tag=tag.
- IDLE: dut_cmd=0, dut_data=0, dut_tag=0.
- Throughput: one command every 2 cycles, back-to-back. Grant-to-first-DUT-cycle latency is 1 cycle.
- Responses: on dut_resp in {1,2} with busy_tags[dut_out_tag]=1, the block registers the following on the next cycle:
  - rsp_valid[owner]=1;
  - rsp_code and rsp_data;
  - clears busy_tags[tag].
- Response latency is therefore 1 cycle. A tag freed in cycle T is allocatable from T+1 onward; a same-cycle free and allocate never reuses it.
- Spurious responses (tag not busy, or resp==3): no rsp_valid, busy_tags unchanged, spurious=1 for 1 cycle.
- Pool exhausted (all NTAG tags busy): req_ready=0. The FSM finishes the current sequence and waits in IDLE.
- Simultaneous events: a grant and a response on different tags in the same cycle are both processed. Responses never stall issue.
- Ordering: responses may arrive out of order; routing depends only on tag, never on order.
- Requester i may have multiple commands outstanding, each on its own tag.

Test Plan:
- Single request, reset released: req0 cmd=1 op1=5 op2=7.
  - DUT cmd=1, data=5, tag=0 at T+1; data=7 at T+2.
  - DUT response resp=1, data=12, tag=0 -> next cycle rsp_valid=0001, rsp_data=12, busy_tags=0000.
- Round-robin: all 4 requesters valid continuously.
  - Grant order is 0,1,2,3 on cycles T, T+2, T+4, T+6.
  - Tags 0,1,2,3 assigned; busy_tags=1111; req_ready stays 0 until a response arrives.
- Out-of-order return: with tags 0..3 outstanding, respond tag 2 then tag 0.
  - rsp_valid=0100 then 0001.
  - The next grant receives tag 0 (lowest free).
- Error and spurious response:
  - resp=2 on busy tag 1 -> rsp_code=2 to the owner; tag 1 freed.
  - resp=1 on free tag 3 -> spurious pulse; no rsp_valid.
- Free/allocate same cycle: pool full, response on tag 1 in cycle T.
  - Tag 1 is granted no earlier than T+1.
- Reset mid-operation: assert reset_n low during ISSUE1.
  - dut_cmd=0 immediately and busy_tags=0.
  - A subsequent DUT response on the old tag -> spurious=1.

Source files
------------

// File: rtl/calc_port_scheduler.sv
// Round-robin sharing of one Calc3 port between NREQ requesters; each issue takes 2 cycles, responses are routed by 2-bit tag.
// Grant to first DUT beat is 1 cycle, response to rsp_valid is 1 cycle; req_ready stays low while ISSUE1 is active or no tag is free.
module calc_port_scheduler #(
  parameter int NREQ = 4,
  parameter int NTAG = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [4*NREQ-1:0]  req_cmd,
  input  logic [32*NREQ-1:0] req_op1,
  input  logic [32*NREQ-1:0] req_op2,
  output logic [3:0]         dut_cmd,
  output logic [31:0]        dut_data,
  output logic [1:0]         dut_tag,
  input  logic [1:0]         dut_resp,
  input  logic [31:0]        dut_out_data,
  input  logic [1:0]         dut_out_tag,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [1:0]         rsp_code,
  output logic [31:0]        rsp_data,
  output logic [NTAG-1:0]    busy_tags,
  output logic               spurious
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      busy_q;
  logic [IW-1:0]   owner_q [4];
  logic [IW-1:0]   rr_ptr_q;
  logic [31:0]     op2_q;
  logic [1:0]      tag_q;

  logic            tag_avail;
  logic [1:0]      free_tag;
  logic            grant_vld;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic [3:0]      cmd_d;
  logic [31:0]     data_d;
  logic [1:0]      tag_d;
  logic            rsp_hit;
  logic            rsp_bad;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NREQ) j = j - NREQ;
    return IW'(j);
  endfunction

  // Allocation reads the registered bitmap, so a tag freed this cycle is not reused until next cycle.
  always_comb begin
    tag_avail = 1'b0;
    free_tag  = '0;
    for (int t = NTAG - 1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        tag_avail = 1'b1;
        free_tag  = 2'(t);
      end
    end
  end

  // Scan from the far end so the requester closest to the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    if ((state_q == IDLE || state_q == ISSUE2) && tag_avail) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand = rr_idx(rr_ptr_q, k);
        if (req_valid[cand] && req_cmd[4*cand +: 4] != 4'd0) begin
          grant_vld = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (grant_vld) req_ready = NREQ'(1) << gnt_idx;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = '0;
    data_d  = '0;
    tag_d   = '0;
    if (grant_vld) begin
      state_d = ISSUE1;
      cmd_d   = req_cmd[4*gnt_idx +: 4];
      data_d  = req_op1[32*gnt_idx +: 32];
      tag_d   = free_tag;
    end else if (state_q == ISSUE1) begin
      state_d = ISSUE2;
      data_d  = op2_q;
      tag_d   = tag_q;
    end else if (state_q == ISSUE2) begin
      state_d = IDLE;
    end
  end

  assign rsp_hit   = (dut_resp == 2'd1 || dut_resp == 2'd2) && busy_q[dut_out_tag];
  assign rsp_bad   = (dut_resp != 2'd0) && !rsp_hit;
  assign busy_tags = busy_q[NTAG-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy_q    <= '0;
      rr_ptr_q  <= '0;
      op2_q     <= '0;
      tag_q     <= '0;
      dut_cmd   <= '0;
      dut_data  <= '0;
      dut_tag   <= '0;
      rsp_valid <= '0;
      rsp_code  <= '0;
      rsp_data  <= '0;
      spurious  <= 1'b0;
      for (int t = 0; t < 4; t++) owner_q[t] <= '0;
    end else begin
      state_q   <= state_d;
      dut_cmd   <= cmd_d;
      dut_data  <= data_d;
      dut_tag   <= tag_d;
      rsp_valid <= '0;
      rsp_code  <= '0;
      rsp_data  <= '0;
      spurious  <= rsp_bad;
      if (rsp_hit) begin
        rsp_valid[owner_q[dut_out_tag]] <= 1'b1;
        rsp_code <= dut_resp;
        rsp_data <= dut_out_data;
      end
      // Freed and allocated tags never coincide: a hit needs a busy tag, allocation a free one.
      busy_q <= (busy_q & ~(rsp_hit ? (4'b1 << dut_out_tag) : 4'b0))
              | (grant_vld ? (4'b1 << free_tag) : 4'b0);
      if (grant_vld) begin
        op2_q             <= req_op2[32*gnt_idx +: 32];
        tag_q             <= free_tag;
        owner_q[free_tag] <= gnt_idx;
        rr_ptr_q          <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Bench for calc_port_scheduler: directed scenarios plus random traffic, all checked against a
// transaction-level model (tag pool, owner table, queue of expected DUT beats).
module tb_calc_port_scheduler;
  localparam int NREQ = 4;
  localparam int NTAG = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [3:0]          cmd_a [NREQ];
  logic [31:0]         op1_a [NREQ];
  logic [31:0]         op2_a [NREQ];
  logic [4*NREQ-1:0]   req_cmd;
  logic [32*NREQ-1:0]  req_op1;
  logic [32*NREQ-1:0]  req_op2;
  logic [3:0]          dut_cmd;
  logic [31:0]         dut_data;
  logic [1:0]          dut_tag;
  logic [1:0]          dut_resp;
  logic [31:0]         dut_out_data;
  logic [1:0]          dut_out_tag;
  logic [NREQ-1:0]     rsp_valid;
  logic [1:0]          rsp_code;
  logic [31:0]         rsp_data;
  logic [NTAG-1:0]     busy_tags;
  logic                spurious;

  always #5 clk = ~clk;

  always_comb begin
    req_cmd = '0;
    req_op1 = '0;
    req_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_cmd[4*i +: 4]   = cmd_a[i];
      req_op1[32*i +: 32] = op1_a[i];
      req_op2[32*i +: 32] = op2_a[i];
    end
  end

  calc_port_scheduler #(.NREQ(NREQ), .NTAG(NTAG)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .dut_cmd(dut_cmd), .dut_data(dut_data), .dut_tag(dut_tag),
    .dut_resp(dut_resp), .dut_out_data(dut_out_data), .dut_out_tag(dut_out_tag),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_data(rsp_data),
    .busy_tags(busy_tags), .spurious(spurious)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] data;
    logic [1:0]  tag;
  } beat_t;

  beat_t           q[$];
  bit              m_busy [NTAG];
  int              m_owner [NTAG];
  int              m_ptr;
  logic [NREQ-1:0] e_rv;
  logic [1:0]      e_code;
  logic [31:0]     e_data;
  logic            e_spur;
  logic [NTAG-1:0] e_busy;
  int              total = 0;
  int              bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int t = 0; t < NTAG; t++) begin
      m_busy[t]  = 1'b0;
      m_owner[t] = 0;
    end
    m_ptr  = 0;
    e_rv   = '0;
    e_code = '0;
    e_data = '0;
    e_spur = 1'b0;
    e_busy = '0;
  endtask

  // Entered just after a falling edge with this cycle's inputs already driven; returns at the next one.
  task automatic cycle();
    beat_t           cur;
    int              gi;
    int              ft;
    int              j;
    logic [NREQ-1:0] exp_gnt;
    cur = '0;
    if (q.size() != 0) cur = q.pop_front();
    chk("dut_cmd", 64'(dut_cmd), 64'(cur.cmd));
    chk("dut_data", 64'(dut_data), 64'(cur.data));
    chk("dut_tag", 64'(dut_tag), 64'(cur.tag));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_code", 64'(rsp_code), 64'(e_code));
    chk("rsp_data", 64'(rsp_data), 64'(e_data));
    chk("spurious", 64'(spurious), 64'(e_spur));
    chk("busy_tags", 64'(busy_tags), 64'(e_busy));
    #1;
    gi = -1;
    ft = -1;
    for (int t = 0; t < NTAG; t++) if (!m_busy[t] && ft < 0) ft = t;
    if (q.size() == 0 && ft >= 0) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (gi < 0 && req_valid[j] && cmd_a[j] != 4'd0) gi = j;
      end
    end
    exp_gnt = (gi >= 0) ? NREQ'(1) << gi : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_gnt));
    e_rv   = '0;
    e_code = '0;
    e_data = '0;
    e_spur = 1'b0;
    if (dut_resp != 2'd0) begin
      if (dut_resp != 2'd3 && m_busy[dut_out_tag]) begin
        e_rv   = NREQ'(1) << m_owner[dut_out_tag];
        e_code = dut_resp;
        e_data = dut_out_data;
        m_busy[dut_out_tag] = 1'b0;
      end else begin
        e_spur = 1'b1;
      end
    end
    if (gi >= 0) begin
      m_busy[ft]  = 1'b1;
      m_owner[ft] = gi;
      m_ptr       = (gi + 1) % NREQ;
      q.push_back(beat_t'{cmd: cmd_a[gi], data: op1_a[gi], tag: 2'(ft)});
      q.push_back(beat_t'{cmd: 4'd0, data: op2_a[gi], tag: 2'(ft)});
    end
    for (int t = 0; t < NTAG; t++) e_busy[t] = m_busy[t];
    @(negedge clk);
  endtask

  task automatic respond(input logic [1:0] code, input logic [1:0] tag, input logic [31:0] data);
    dut_resp     = code;
    dut_out_tag  = tag;
    dut_out_data = data;
    cycle();
    dut_resp     = 2'd0;
    dut_out_tag  = 2'd0;
    dut_out_data = '0;
  endtask

  task automatic do_reset();
    req_valid = '0;
    dut_resp  = 2'd0;
    reset_n   = 1'b0;
    #1;
    chk("rst_dut_cmd", 64'(dut_cmd), 64'd0);
    chk("rst_busy", 64'(busy_tags), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int bt [$];
    req_valid    = '0;
    dut_resp     = 2'd0;
    dut_out_tag  = 2'd0;
    dut_out_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      cmd_a[i] = 4'd0;
      op1_a[i] = '0;
      op2_a[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_dut_cmd", 64'(dut_cmd), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_spurious", 64'(spurious), 64'd0);
    chk("reset_busy", 64'(busy_tags), 64'd0);
    reset_n = 1'b1;

    // Single request
    req_valid = 4'b0001; cmd_a[0] = 4'd1; op1_a[0] = 32'd5; op2_a[0] = 32'd7;
    cycle();
    req_valid = '0;
    chk("single_beat1_cmd", 64'(dut_cmd), 64'd1);
    chk("single_beat1_data", 64'(dut_data), 64'd5);
    chk("single_beat1_tag", 64'(dut_tag), 64'd0);
    cycle();
    chk("single_beat2_data", 64'(dut_data), 64'd7);
    cycle();
    respond(2'd1, 2'd0, 32'd12);
    chk("single_rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("single_rsp_data", 64'(rsp_data), 64'd12);
    chk("single_busy_free", 64'(busy_tags), 64'd0);
    cycle();

    // Round robin from reset fills the pool with tag i owned by requester i
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      cmd_a[i] = 4'(i + 1);
      op1_a[i] = $urandom;
      op2_a[i] = $urandom;
    end
    repeat (8) cycle();
    chk("rr_busy_full", 64'(busy_tags), 64'hF);
    chk("rr_ready_full", 64'(req_ready), 64'd0);
    repeat (2) cycle();

    // Out-of-order return, then lowest free tag is reused
    req_valid = '0;
    respond(2'd1, 2'd2, 32'h22);
    chk("ooo_first_owner", 64'(rsp_valid), 64'b0100);
    respond(2'd1, 2'd0, 32'h00);
    chk("ooo_second_owner", 64'(rsp_valid), 64'b0001);
    cmd_a[1] = 4'd9;
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    chk("ooo_realloc_tag", 64'(dut_tag), 64'd0);
    chk("ooo_realloc_cmd", 64'(dut_cmd), 64'd9);
    repeat (2) cycle();

    // Error response, then a response on a tag that is no longer busy
    respond(2'd2, 2'd1, 32'hBAD);
    chk("err_code", 64'(rsp_code), 64'd2);
    chk("err_owner", 64'(rsp_valid), 64'b0010);
    chk("err_busy", 64'(busy_tags), 64'b1001);
    respond(2'd1, 2'd3, 32'h33);
    respond(2'd1, 2'd3, 32'h44);
    chk("spur_pulse", 64'(spurious), 64'd1);
    chk("spur_no_rsp", 64'(rsp_valid), 64'd0);

    // Pool full: a tag freed in cycle T is granted no earlier than T+1
    req_valid = 4'b1111;
    n = 0;
    while (busy_tags != 4'hF && n < 20) begin
      cycle();
      n++;
    end
    chk("fill_pool", 64'(busy_tags), 64'hF);
    repeat (2) cycle();
    chk("same_cycle_no_grant", 64'(req_ready), 64'd0);
    respond(2'd1, 2'd1, 32'h11);
    chk("next_cycle_grant", 64'(req_ready != '0), 64'd1);
    cycle();
    chk("next_cycle_tag", 64'(dut_tag), 64'd1);
    req_valid = '0;
    repeat (2) cycle();

    // Reset during ISSUE1, then a late response on the discarded tag
    do_reset();
    req_valid = 4'b0001; cmd_a[0] = 4'd3;
    cycle();
    req_valid = '0;
    chk("mid_issue1_cmd", 64'(dut_cmd), 64'd3);
    do_reset();
    respond(2'd1, 2'd0, 32'h55);
    chk("mid_late_spur", 64'(spurious), 64'd1);
    cycle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 50);
        cmd_a[i]     = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        op1_a[i]     = $urandom;
        op2_a[i]     = $urandom;
      end
      dut_resp     = 2'd0;
      dut_out_tag  = 2'd0;
      dut_out_data = $urandom;
      if ($urandom_range(0, 99) < 35) begin
        bt.delete();
        for (int t = 0; t < NTAG; t++) if (m_busy[t]) bt.push_back(t);
        if (bt.size() != 0 && $urandom_range(0, 9) < 8)
          dut_out_tag = 2'(bt[$urandom_range(0, bt.size() - 1)]);
        else
          dut_out_tag = 2'($urandom_range(0, 3));
        dut_resp = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(1, 2));
      end
      cycle();
    end
    dut_resp  = 2'd0;
    req_valid = '0;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
